// File: rtl/wbslv_pkg.sv
// rtl/wbslv_pkg.sv - shared types and helpers for the TMR wishbone register bank
package wbslv_pkg;

  localparam int REG_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESP     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/tmr_vote3.sv
// rtl/tmr_vote3.sv - 2-of-3 majority vote with lane disagreement flag
module tmr_vote3
  import wbslv_pkg::*;
(
  input  logic [2:0] lanes,
  output logic       voted,
  output logic       mismatch
);

  assign voted    = maj3(lanes);
  assign mismatch = ~((lanes[0] == lanes[1]) && (lanes[1] == lanes[2]));

endmodule

// File: rtl/wbslv_tmr_regbank.sv
// rtl/wbslv_tmr_regbank.sv - wishbone slave register bank behind a triplicated handshake
module wbslv_tmr_regbank
  import wbslv_pkg::*;
#(
  parameter int WbDataWidth  = 16,
  parameter int WbAddWidth   = 12,
  parameter int G_MODULE_ID  = 1,
  parameter int G_NUM_RW     = 8,
  parameter int G_NUM_RO     = 4,
  parameter int G_RW_RST_VAL = 0,
  parameter int G_K_TMR      = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [G_K_TMR-1:0]                 wbs_we_i,
  input  logic [G_K_TMR-1:0]                 wbs_stb_i,
  input  logic [G_K_TMR-1:0]                 wbs_cyc_i,
  output logic [G_K_TMR-1:0]                 wbs_ack_o,
  output logic [G_K_TMR-1:0]                 wbs_err_o,
  input  logic [WbAddWidth-1:0]              wbs_adr_i,
  input  logic [WbDataWidth-1:0]             wbs_dt_i,
  output logic [WbDataWidth-1:0]             wbs_dt_o,
  output logic [G_NUM_RW*WbDataWidth-1:0]    rw_regs_o,
  input  logic [G_NUM_RO*WbDataWidth-1:0]    ro_regs_i,
  output logic [G_NUM_RW-1:0]                wr_pulse_o,
  output logic [G_NUM_RW+G_NUM_RO-1:0]       rd_pulse_o,
  output logic [WbDataWidth-1:0]             errcnt_o,
  input  logic                               rst_errcnt_i,
  output logic                               mismatch_o
);

  localparam int NUM_REGS = G_NUM_RW + G_NUM_RO;
  localparam int MOD_W    = WbAddWidth - REG_ADDR_W;
  localparam logic [MOD_W-1:0]       MOD_ID    = MOD_W'(G_MODULE_ID);
  localparam logic [REG_ADDR_W-1:0]  RW_LIMIT  = REG_ADDR_W'(G_NUM_RW);
  localparam logic [REG_ADDR_W-1:0]  ALL_LIMIT = REG_ADDR_W'(NUM_REGS);
  localparam logic [WbDataWidth-1:0] RST_VAL   = WbDataWidth'(G_RW_RST_VAL);

  logic we_v, stb_v, cyc_v;
  logic we_mm, stb_mm, cyc_mm;

  tmr_vote3 u_vote_we  (.lanes(wbs_we_i),  .voted(we_v),  .mismatch(we_mm));
  tmr_vote3 u_vote_stb (.lanes(wbs_stb_i), .voted(stb_v), .mismatch(stb_mm));
  tmr_vote3 u_vote_cyc (.lanes(wbs_cyc_i), .voted(cyc_v), .mismatch(cyc_mm));

  state_t state_q, state_d;

  logic [WbDataWidth-1:0]       rw_q [G_NUM_RW];
  logic [WbDataWidth-1:0]       dt_q;
  logic [WbDataWidth-1:0]       errcnt_q;
  logic [G_NUM_RW-1:0]          wr_pulse_q;
  logic [NUM_REGS-1:0]          rd_pulse_q;
  logic                         ack_q, err_q, mismatch_q;

  logic [REG_ADDR_W-1:0]        reg_adr;
  logic [MOD_W-1:0]             mod_adr;
  logic                         req, start, acc_err;
  logic [WbDataWidth-1:0]       rd_mux;

  assign reg_adr = wbs_adr_i[REG_ADDR_W-1:0];
  assign mod_adr = wbs_adr_i[WbAddWidth-1:REG_ADDR_W];
  assign req     = cyc_v & stb_v & (mod_adr == MOD_ID);

  // Writes may only target RW registers; reads may target RW or RO.
  always_comb begin
    acc_err = we_v ? (reg_adr >= RW_LIMIT) : (reg_adr >= ALL_LIMIT);
    rd_mux  = '0;
    for (int i = 0; i < G_NUM_RW; i++) begin
      if (reg_adr == REG_ADDR_W'(i)) rd_mux = rw_q[i];
    end
    for (int j = 0; j < G_NUM_RO; j++) begin
      if (reg_adr == REG_ADDR_W'(G_NUM_RW + j)) rd_mux = ro_regs_i[j*WbDataWidth +: WbDataWidth];
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RESP;
          start   = 1'b1;
        end
      end
      RESP:     state_d = WAIT_REL;
      WAIT_REL: if (!stb_v) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < G_NUM_RW; i++) rw_q[i] <= RST_VAL;
      dt_q       <= '0;
      errcnt_q   <= '0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      mismatch_q <= we_mm | stb_mm | cyc_mm;
      if (start) begin
        if (acc_err) begin
          err_q <= 1'b1;
        end else begin
          ack_q <= 1'b1;
          if (we_v) begin
            for (int i = 0; i < G_NUM_RW; i++) begin
              if (reg_adr == REG_ADDR_W'(i)) begin
                rw_q[i]       <= wbs_dt_i;
                wr_pulse_q[i] <= 1'b1;
              end
            end
          end else begin
            dt_q <= rd_mux;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (reg_adr == REG_ADDR_W'(i)) rd_pulse_q[i] <= 1'b1;
            end
          end
        end
      end
      // Clear has priority over a coincident error increment.
      if (rst_errcnt_i)
        errcnt_q <= '0;
      else if (start && acc_err && (errcnt_q != '1))
        errcnt_q <= errcnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < G_NUM_RW; g++) begin : g_rw_out
    assign rw_regs_o[g*WbDataWidth +: WbDataWidth] = rw_q[g];
  end

  assign wbs_ack_o  = {G_K_TMR{ack_q}};
  assign wbs_err_o  = {G_K_TMR{err_q}};
  assign wbs_dt_o   = dt_q;
  assign wr_pulse_o = wr_pulse_q;
  assign rd_pulse_o = rd_pulse_q;
  assign errcnt_o   = errcnt_q;
  assign mismatch_o = mismatch_q;

endmodule

// File: tb/tb_wbslv_tmr_regbank.sv
// tb/tb_wbslv_tmr_regbank.sv - scoreboard bench for the TMR wishbone register bank
module tb_wbslv_tmr_regbank;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [2:0]   wbs_we_i, wbs_stb_i, wbs_cyc_i;
  logic [2:0]   wbs_ack_o, wbs_err_o;
  logic [11:0]  wbs_adr_i;
  logic [15:0]  wbs_dt_i, wbs_dt_o;
  logic [127:0] rw_regs_o;
  logic [63:0]  ro_regs_i;
  logic [7:0]   wr_pulse_o;
  logic [11:0]  rd_pulse_o;
  logic [15:0]  errcnt_o;
  logic         rst_errcnt_i;
  logic         mismatch_o;

  always #5 clk = ~clk;

  wbslv_tmr_regbank dut (
    .clk_i(clk), .rst_i(rst_i),
    .wbs_we_i(wbs_we_i), .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .wbs_adr_i(wbs_adr_i), .wbs_dt_i(wbs_dt_i), .wbs_dt_o(wbs_dt_o),
    .rw_regs_o(rw_regs_o), .ro_regs_i(ro_regs_i),
    .wr_pulse_o(wr_pulse_o), .rd_pulse_o(rd_pulse_o),
    .errcnt_o(errcnt_o), .rst_errcnt_i(rst_errcnt_i), .mismatch_o(mismatch_o)
  );

  typedef struct {
    logic        is_err;
    logic        chk_dt;
    logic [15:0] dt;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_rw [8];
  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  int          resp_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rw_vec();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = exp_rw[i];
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (wbs_ack_o != 3'b000 || wbs_err_o != 3'b000) begin
      resp_cnt++;
      ok = (wbs_ack_o == 3'b111 && wbs_err_o == 3'b000) ||
           (wbs_err_o == 3'b111 && wbs_ack_o == 3'b000);
      chk("resp_lanes", {127'd0, ok}, 128'd1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got ack=%b err=%b want none", wbs_ack_o, wbs_err_o);
      end else begin
        e = sb.pop_front();
        chk("resp_kind", {127'd0, wbs_err_o[0]}, {127'd0, e.is_err});
        chk("resp_cycle", 128'(cyc_cnt), 128'(e.cyc));
        if (e.chk_dt) chk("resp_data", {112'd0, wbs_dt_o}, {112'd0, e.dt});
      end
    end
  end

  task automatic access(input logic we, input logic [11:0] adr, input logic [15:0] dat,
                        input int hold, input logic [2:0] stb_l,
                        input logic exp_resp, input logic exp_err, input logic exp_chk,
                        input logic [15:0] exp_dt, input logic [7:0] exp_wr,
                        input logic [11:0] exp_rd, input string nm);
    logic nonuni;
    nonuni    = (stb_l != 3'b000) && (stb_l != 3'b111);
    wbs_we_i  = {3{we}};
    wbs_stb_i = stb_l;
    wbs_cyc_i = 3'b111;
    wbs_adr_i = adr;
    wbs_dt_i  = dat;
    if (exp_resp)
      sb.push_back('{is_err: exp_err, chk_dt: exp_chk, dt: exp_dt, cyc: cyc_cnt + 1});
    @(posedge clk); #1;
    chk({nm, "_wr_pulse"}, {120'd0, wr_pulse_o}, {120'd0, exp_wr});
    chk({nm, "_rd_pulse"}, {116'd0, rd_pulse_o}, {116'd0, exp_rd});
    chk({nm, "_mismatch"}, {127'd0, mismatch_o}, {127'd0, nonuni});
    for (int k = 1; k < hold; k++) begin
      @(posedge clk); #1;
    end
    wbs_we_i  = 3'b000;
    wbs_stb_i = 3'b000;
    wbs_cyc_i = 3'b000;
    @(posedge clk); #1;
    chk({nm, "_pulses_end"}, {108'd0, wr_pulse_o, rd_pulse_o}, 128'd0);
    if (hold == 1) chk({nm, "_mismatch_end"}, {127'd0, mismatch_o}, 128'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int r0;
    rst_i        = 1'b1;
    wbs_we_i     = 3'b000;
    wbs_stb_i    = 3'b000;
    wbs_cyc_i    = 3'b000;
    wbs_adr_i    = '0;
    wbs_dt_i     = '0;
    rst_errcnt_i = 1'b0;
    ro_regs_i    = {16'hD0D3, 16'hC0C2, 16'h1234, 16'hA0A0};
    for (int i = 0; i < 8; i++) exp_rw[i] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_err", {122'd0, wbs_ack_o, wbs_err_o}, 128'd0);
    chk("rst_dt", {112'd0, wbs_dt_o}, 128'd0);
    chk("rst_errcnt", {112'd0, errcnt_o}, 128'd0);
    chk("rst_mismatch", {127'd0, mismatch_o}, 128'd0);
    chk("rst_pulses", {108'd0, wr_pulse_o, rd_pulse_o}, 128'd0);
    chk("rst_rw", rw_regs_o, rw_vec());
    chk("rst_state", {126'd0, dut.state_q}, 128'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    r0 = resp_cnt;
    access(1'b1, 12'h102, 16'hBEEF, 4, 3'b111, 1, 0, 0, 16'h0, 8'h04, 12'h000, "t1");
    exp_rw[2] = 16'hBEEF;
    chk("t1_single_ack", 128'(resp_cnt - r0), 128'd1);
    chk("t1_rw", rw_regs_o, rw_vec());

    access(1'b0, 12'h109, 16'h0, 2, 3'b111, 1, 0, 1, 16'h1234, 8'h00, 12'h200, "t2_ro");
    access(1'b0, 12'h102, 16'h0, 1, 3'b111, 1, 0, 1, 16'hBEEF, 8'h00, 12'h004, "t2_rw");

    access(1'b1, 12'h10A, 16'h0005, 1, 3'b111, 1, 1, 0, 16'h0, 8'h00, 12'h000, "t3_wro");
    access(1'b0, 12'h1C8, 16'h0, 1, 3'b111, 1, 1, 0, 16'h0, 8'h00, 12'h000, "t3_rbad");
    chk("t3_errcnt2", {112'd0, errcnt_o}, 128'd2);
    chk("t3_rw", rw_regs_o, rw_vec());
    chk("t3_dt_hold", {112'd0, wbs_dt_o}, {112'd0, 16'hBEEF});
    rst_errcnt_i = 1'b1;
    access(1'b0, 12'h10C, 16'h0, 1, 3'b111, 1, 1, 0, 16'h0, 8'h00, 12'h000, "t3_clr");
    rst_errcnt_i = 1'b0;
    chk("t3_errcnt_clr", {112'd0, errcnt_o}, 128'd0);
    access(1'b1, 12'h10B, 16'h0007, 1, 3'b111, 1, 1, 0, 16'h0, 8'h00, 12'h000, "t3_again");
    chk("t3_errcnt1", {112'd0, errcnt_o}, 128'd1);

    access(1'b1, 12'h202, 16'h1111, 2, 3'b111, 0, 0, 0, 16'h0, 8'h00, 12'h000, "t4");
    chk("t4_rw", rw_regs_o, rw_vec());
    chk("t4_state", {126'd0, dut.state_q}, 128'd0);

    access(1'b1, 12'h103, 16'h00C3, 1, 3'b101, 1, 0, 0, 16'h0, 8'h08, 12'h000, "t5a");
    exp_rw[3] = 16'h00C3;
    chk("t5a_rw", rw_regs_o, rw_vec());
    access(1'b1, 12'h104, 16'h4444, 1, 3'b001, 0, 0, 0, 16'h0, 8'h00, 12'h000, "t5b");
    chk("t5b_rw", rw_regs_o, rw_vec());

    access(1'b1, 12'h105, 16'h5555, 1, 3'b111, 1, 0, 0, 16'h0, 8'h20, 12'h000, "t6_pre");
    wbs_we_i  = 3'b111;
    wbs_stb_i = 3'b111;
    wbs_cyc_i = 3'b111;
    wbs_adr_i = 12'h106;
    wbs_dt_i  = 16'h6666;
    sb.push_back('{is_err: 1'b0, chk_dt: 1'b0, dt: 16'h0, cyc: cyc_cnt + 1});
    @(posedge clk); #1;
    rst_i = 1'b1;
    chk("t6_resp_ack", {125'd0, wbs_ack_o}, 128'd7);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) exp_rw[i] = 16'h0000;
    chk("t6_ack_cleared", {125'd0, wbs_ack_o}, 128'd0);
    chk("t6_rw_reset", rw_regs_o, rw_vec());
    chk("t6_errcnt_reset", {112'd0, errcnt_o}, 128'd0);
    chk("t6_dt_reset", {112'd0, wbs_dt_o}, 128'd0);
    rst_i     = 1'b0;
    wbs_we_i  = 3'b000;
    wbs_stb_i = 3'b000;
    wbs_cyc_i = 3'b000;
    @(posedge clk); #1;
    access(1'b1, 12'h101, 16'h0101, 1, 3'b111, 1, 0, 0, 16'h0, 8'h02, 12'h000, "t6_post");
    exp_rw[1] = 16'h0101;
    chk("t6_post_rw", rw_regs_o, rw_vec());

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
